// File: rtl/axi4_lite_fanout_rd_n.sv
// AXI4-Lite read fanout: one slave read port routed to NM master read ports
// through a BASE/MASK address map. Responses come back in order only, so the
// block stays locked on one target until every outstanding read has returned.
// Unmapped reads are answered locally with DECERR.
module axi4_lite_fanout_rd_n #(
    parameter int              A       = 32,
    parameter int              D       = 32,
    parameter int              NM      = 4,
    parameter int              MAX_OUT = 4,
    parameter logic [NM*A-1:0] BASE    = '0,
    parameter logic [NM*A-1:0] MASK    = '0
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic [A-1:0]    s_araddr,
    input  logic            s_arvalid,
    output logic            s_arready,
    output logic [D-1:0]    s_rdata,
    output logic [1:0]      s_rresp,
    output logic            s_rvalid,
    input  logic            s_rready,
    output logic [A-1:0]    m_araddr,
    output logic [NM-1:0]   m_arvalid,
    input  logic [NM-1:0]   m_arready,
    input  logic [NM*D-1:0] m_rdata,
    input  logic [NM*2-1:0] m_rresp,
    input  logic [NM-1:0]   m_rvalid,
    output logic [NM-1:0]   m_rready
);
    localparam int            TW      = $clog2(NM);
    localparam int            CW      = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, BUSY, DECERR} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;      // reads accepted but not yet answered
    logic [TW-1:0] tgt_q;      // port currently owning the read path
    logic          ar_vld_q;   // AR stage holds a request for port tgt_q
    logic [A-1:0]  araddr_q;

    logic [NM-1:0] hit;
    logic          mapped;
    logic [TW-1:0] sel;
    logic [NM-1:0] tgt_oh;
    logic          ar_ok;
    logic          ar_hs;
    logic          ar_map_hs;
    logic          r_hs;

    for (genvar i = 0; i < NM; i++) begin : g_dec
        assign hit[i] = ((s_araddr & MASK[i*A +: A]) == BASE[i*A +: A]);
    end

    // Priority encode the decode hits; the lowest index wins on overlap
    always_comb begin
        mapped = 1'b0;
        sel    = '0;
        for (int i = NM - 1; i >= 0; i--) begin
            if (hit[i]) begin
                mapped = 1'b1;
                sel    = TW'(i);
            end
        end
    end

    assign tgt_oh = NM'(1) << tgt_q;

    // AR acceptance: in BUSY only same-target reads may join, and only while
    // the stage can take them and the outstanding limit is not reached
    always_comb begin
        ar_ok = 1'b0;
        case (state_q)
            IDLE:    ar_ok = !ar_vld_q;
            BUSY:    ar_ok = (!ar_vld_q || m_arready[tgt_q]) && mapped &&
                             (sel == tgt_q) && (cnt_q < CNT_MAX);
            default: ar_ok = 1'b0;
        endcase
    end

    // Held low while reset is asserted so the slave never sees a ready
    assign s_arready = aresetn && ar_ok;
    assign ar_hs     = s_arvalid && s_arready;
    assign ar_map_hs = ar_hs && mapped;

    // Return path: mux the owning port in BUSY, synthesize DECERR locally
    always_comb begin
        s_rvalid = 1'b0;
        s_rdata  = '0;
        s_rresp  = 2'b00;
        case (state_q)
            BUSY: begin
                s_rvalid = m_rvalid[tgt_q];
                s_rdata  = m_rdata[tgt_q*D +: D];
                s_rresp  = m_rresp[tgt_q*2 +: 2];
            end
            DECERR: begin
                s_rvalid = 1'b1;
                s_rresp  = 2'b11;
            end
            default: ;
        endcase
    end

    assign r_hs      = (state_q == BUSY) && s_rvalid && s_rready;
    assign m_rready  = (s_rready && (state_q == BUSY)) ? tgt_oh : '0;
    assign m_arvalid = ar_vld_q ? tgt_oh : '0;
    assign m_araddr  = araddr_q;

    // Control FSM, outstanding counter and single-entry AR stage
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tgt_q    <= '0;
            ar_vld_q <= 1'b0;
            araddr_q <= '0;
        end else begin
            // A new accept takes priority so a drain and reload share a cycle
            if (ar_map_hs) begin
                ar_vld_q <= 1'b1;
                araddr_q <= s_araddr;
            end else if (ar_vld_q && m_arready[tgt_q]) begin
                ar_vld_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (ar_hs) begin
                        if (mapped) begin
                            tgt_q   <= sel;
                            cnt_q   <= CNT_ONE;
                            state_q <= BUSY;
                        end else begin
                            state_q <= DECERR;
                        end
                    end
                end
                BUSY: begin
                    if (ar_map_hs && !r_hs) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end else if (!ar_map_hs && r_hs) begin
                        cnt_q <= cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) state_q <= IDLE;
                    end
                end
                DECERR: begin
                    if (s_rready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_fanout_rd_n.sv
// Randomized scoreboard bench for axi4_lite_fanout_rd_n with NM=4 ports at
// 0x0000/0x1000/0x2000/0x3000 (mask 0xF000) and downstream slave models.
module tb_axi4_lite_fanout_rd_n;
    localparam int A = 32;
    localparam int D = 32;
    localparam int NM = 4;
    localparam int MAX_OUT = 4;
    localparam logic [NM*A-1:0] BASE = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
    localparam logic [NM*A-1:0] MASK = {4{32'h0000_F000}};

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [A-1:0]    s_araddr;
    logic            s_arvalid;
    logic            s_arready;
    logic [D-1:0]    s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rvalid;
    logic            s_rready;
    logic [A-1:0]    m_araddr;
    logic [NM-1:0]   m_arvalid;
    logic [NM-1:0]   m_arready;
    logic [NM*D-1:0] m_rdata;
    logic [NM*2-1:0] m_rresp;
    logic [NM-1:0]   m_rvalid;
    logic [NM-1:0]   m_rready;

    axi4_lite_fanout_rd_n #(.A(A), .D(D), .NM(NM), .MAX_OUT(MAX_OUT), .BASE(BASE), .MASK(MASK)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [D-1:0] data;
        logic [1:0]   resp;
    } rsp_t;

    int   checks = 0;
    int   errors = 0;
    rsp_t exp_q[$];               // expected slave-side responses, in order
    int   last_port = -1;         // port of newest accepted read, -1 = DECERR/none
    logic [A-1:0] pq [NM][16];    // per-port downstream accepted addresses
    int   pq_wr[NM];
    int   pq_rd[NM];
    int   port_dly[NM];
    bit   spur[NM];
    bit   mr_hs[NM];
    bit   sar_hs = 0;
    bit   run_ar = 0;
    bit   rsp_hold = 0;
    bit   fix_region = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Address map in plain terms: region = addr[15:12], ports own regions 0..3
    function automatic int region_of(input logic [A-1:0] a);
        return int'(a[15:12]);
    endfunction

    // Contents of port p's register bank
    function automatic logic [D-1:0] port_data(input int p, input logic [A-1:0] a);
        return (a ^ 32'hA5A5_0000) + 32'(p) * 32'h0101_0101;
    endfunction

    function automatic logic [1:0] port_resp(input logic [A-1:0] a);
        return (a[3:2] == 2'b11) ? 2'b10 : 2'b00;
    endfunction

    function automatic rsp_t model_rsp(input logic [A-1:0] a);
        rsp_t r;
        if (region_of(a) < NM) begin
            r.data = port_data(region_of(a), a);
            r.resp = port_resp(a);
        end else begin
            r.data = '0;
            r.resp = 2'b11;
        end
        return r;
    endfunction

    function automatic logic [A-1:0] gen_addr();
        logic [A-1:0] a;
        int r;
        a = $urandom();
        if (fix_region) r = 1;
        else if (last_port >= 0 && $urandom_range(0, 3) != 0) r = last_port;
        else begin
            r = $urandom_range(0, 5);
            if (r == 5) r = 12;
        end
        a[15:12] = 4'(r);
        return a;
    endfunction

    task automatic clear_models();
        exp_q.delete();
        last_port = -1;
        sar_hs = 0;
        s_arvalid = 0; s_araddr = '0; s_rready = 0;
        m_arready = '0; m_rvalid = '0; m_rdata = '0; m_rresp = '0;
        for (int i = 0; i < NM; i++) begin
            pq_wr[i] = 0; pq_rd[i] = 0; port_dly[i] = 0; spur[i] = 0; mr_hs[i] = 0;
        end
    endtask

    // Stimulus driver: slave-side master and downstream slave models
    initial begin : drv
        forever begin
            @(posedge aclk);
            #1;
            if (!aresetn) continue;
            if (!s_arvalid || sar_hs) begin
                if (run_ar && $urandom_range(0, 3) != 0) begin
                    s_arvalid = 1'b1;
                    s_araddr  = gen_addr();
                end else begin
                    s_arvalid = 1'b0;
                end
            end
            sar_hs = 0;
            s_rready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NM; i++) begin
                m_arready[i] = ($urandom_range(0, 3) != 0);
                if (mr_hs[i] || spur[i]) begin
                    m_rvalid[i] = 1'b0;
                    mr_hs[i] = 0;
                    spur[i] = 0;
                end
                if (!m_rvalid[i]) begin
                    if (pq_wr[i] != pq_rd[i]) begin
                        if (!rsp_hold) begin
                            if (port_dly[i] > 0) port_dly[i]--;
                            else begin
                                m_rvalid[i] = 1'b1;
                                m_rdata[i*D +: D] = port_data(i, pq[i][pq_rd[i] % 16]);
                                m_rresp[i*2 +: 2] = port_resp(pq[i][pq_rd[i] % 16]);
                                port_dly[i] = $urandom_range(0, 4);
                            end
                        end
                    end else if (i != last_port && $urandom_range(0, 7) == 0) begin
                        // stray response on a port that owns nothing
                        m_rvalid[i] = 1'b1;
                        spur[i] = 1;
                        m_rdata[i*D +: D] = $urandom();
                        m_rresp[i*2 +: 2] = 2'b01;
                    end
                end
            end
        end
    end

    // Monitor: samples at negedge, scoreboards responses and checks protocol
    initial begin : mon
        rsp_t e;
        bit ar_chk;
        logic [NM-1:0] ar_oh;
        logic [A-1:0] ar_addr;
        bit prev_rstall;
        logic [D+1:0] prev_r;
        logic [NM-1:0] prev_mar;
        logic [A-1:0] prev_maddr;
        logic [NM-1:0] msk;
        ar_chk = 0; prev_rstall = 0; prev_mar = '0; prev_r = '0; prev_maddr = '0; ar_oh = '0; ar_addr = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                ar_chk = 0; prev_rstall = 0; prev_mar = '0;
                continue;
            end
            if (ar_chk) begin
                chk("m_arvalid_after_ar", 64'(m_arvalid), 64'(ar_oh));
                chk("m_araddr_after_ar", 64'(m_araddr), 64'(ar_addr));
                ar_chk = 0;
            end
            if (prev_rstall) begin
                chk("s_rvalid_hold", 64'(s_rvalid), 64'(1));
                chk("s_r_payload_hold", 64'({s_rdata, s_rresp}), 64'(prev_r));
            end
            if (prev_mar != '0) begin
                chk("m_arvalid_hold", 64'(m_arvalid & prev_mar), 64'(prev_mar));
                chk("m_araddr_hold", 64'(m_araddr), 64'(prev_maddr));
            end
            chk("m_arvalid_onehot", 64'($onehot0(m_arvalid)), 64'(1));

            // acceptance rules
            if (exp_q.size() == 0) chk("s_arready_idle", 64'(s_arready), 64'(1));
            else if (exp_q.size() >= MAX_OUT) chk("s_arready_full", 64'(s_arready), 64'(0));
            else if (s_arvalid && region_of(s_araddr) != last_port)
                chk("s_arready_other_tgt", 64'(s_arready), 64'(0));

            // only the owning port may be drained
            msk = (exp_q.size() != 0 && last_port >= 0) ? (NM'(1) << last_port) : '0;
            chk("m_rready_non_tgt", 64'(m_rready & ~msk), 64'(0));

            if (s_rvalid && s_rready) begin
                if (exp_q.size() == 0) chk("s_r_unexpected", 64'(s_rvalid), 64'(0));
                else begin
                    e = exp_q.pop_front();
                    chk("s_rdata", 64'(s_rdata), 64'(e.data));
                    chk("s_rresp", 64'(s_rresp), 64'(e.resp));
                end
            end
            if (s_arvalid && s_arready) begin
                exp_q.push_back(model_rsp(s_araddr));
                sar_hs = 1;
                if (region_of(s_araddr) < NM) begin
                    last_port = region_of(s_araddr);
                    ar_chk = 1;
                    ar_oh = NM'(1) << last_port;
                    ar_addr = s_araddr;
                end else begin
                    last_port = -1;
                end
            end
            for (int i = 0; i < NM; i++) begin
                if (m_arvalid[i] && m_arready[i]) begin
                    chk("m_ar_route", 64'(region_of(m_araddr)), 64'(i));
                    pq[i][pq_wr[i] % 16] = m_araddr;
                    pq_wr[i]++;
                end
                if (m_rvalid[i] && m_rready[i] && !spur[i]) begin
                    pq_rd[i]++;
                    mr_hs[i] = 1;
                end
            end
            prev_rstall = s_rvalid && !s_rready;
            prev_r      = {s_rdata, s_rresp};
            prev_mar    = m_arvalid & ~m_arready;
            prev_maddr  = m_araddr;
        end
    end

    task automatic drain(input string name);
        int c;
        run_ar = 0;
        c = 0;
        while (c < 2000 && (exp_q.size() != 0 || s_arvalid)) begin
            @(posedge aclk);
            c++;
        end
        chk(name, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin : main
        int c;
        aresetn = 1'b0;
        clear_models();
        repeat (3) @(posedge aclk);
        #2;
        chk("rst_s_arready", 64'(s_arready), 64'(0));
        chk("rst_s_rvalid", 64'(s_rvalid), 64'(0));
        chk("rst_s_r_payload", 64'({s_rdata, s_rresp}), 64'(0));
        chk("rst_m_arvalid", 64'(m_arvalid), 64'(0));
        chk("rst_m_rready", 64'(m_rready), 64'(0));
        chk("rst_m_araddr", 64'(m_araddr), 64'(0));
        @(posedge aclk);
        #3 aresetn = 1'b1;

        run_ar = 1;
        repeat (3000) @(posedge aclk);
        drain("drain_timeout_1");

        // fill to the outstanding limit on one port with responses withheld
        fix_region = 1;
        rsp_hold = 1;
        run_ar = 1;
        c = 0;
        while (c < 400 && exp_q.size() < MAX_OUT) begin
            @(posedge aclk);
            c++;
        end
        chk("fill_to_max_out", 64'(exp_q.size()), 64'(MAX_OUT));
        repeat (5) @(posedge aclk);

        // asynchronous reset in the middle of traffic
        #3 aresetn = 1'b0;
        #1;
        chk("mid_rst_s_arready", 64'(s_arready), 64'(0));
        chk("mid_rst_m_arvalid", 64'(m_arvalid), 64'(0));
        chk("mid_rst_m_rready", 64'(m_rready), 64'(0));
        chk("mid_rst_s_rvalid", 64'(s_rvalid), 64'(0));
        chk("mid_rst_m_araddr", 64'(m_araddr), 64'(0));
        run_ar = 0;
        fix_region = 0;
        rsp_hold = 0;
        clear_models();
        @(posedge aclk);
        #3 aresetn = 1'b1;
        @(negedge aclk);
        chk("post_rst_s_arready", 64'(s_arready), 64'(1));

        run_ar = 1;
        repeat (1500) @(posedge aclk);
        drain("drain_timeout_2");
        repeat (3) @(posedge aclk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_fanout_rd_n.md
Name: axi4_lite_fanout_rd_n

Overview:
- Parametrised AXI4-Lite read fanout: one slave-side read port routed to NM master-side read ports by a per-port BASE/MASK address map.
- Generalises the two-port, single-threshold read splitter to NM ports with configurable outstanding depth and DECERR generation for unmapped addresses.
- Sits between an interconnect/crossbar read path and NM peripheral register banks.
- In-order responses only: no IDs, so target switching waits for all outstanding responses to drain.

Parameters:
- A, 32, address width.
- D, 32, data width.
- NM, 4, number of master ports (2..16).
- MAX_OUT, 4, max outstanding reads (1..15).
- BASE, 0, NM*A packed bits; port i base address at [i*A +: A].
- MASK, 0, NM*A packed bits; port i decode mask at [i*A +: A].

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_araddr  in  A  slave read address
- s_arvalid  in  1  slave AR valid
- s_arready  out  1  slave AR ready
- s_rdata  out  D  slave read data
- s_rresp  out  2  slave read response
- s_rvalid  out  1  slave R valid
- s_rready  in  1  slave R ready
- m_araddr  out  A  master read address, shared by all ports
- m_arvalid  out  NM  per-port AR valid
- m_arready  in  NM  per-port AR ready
- m_rdata  in  NM*D  per-port read data, port i at [i*D +: D]
- m_rresp  in  NM*2  per-port read response
- m_rvalid  in  NM  per-port R valid
- m_rready  out  NM  per-port R ready

Behaviour:
- Reset (async assert, sync release on aclk):
  - s_arready=0, s_rvalid=0, s_rresp=0, s_rdata=0.
  - m_arvalid=0, m_rready=0, m_araddr=0.
  - cnt=0, tgt=0, state=IDLE.
- Decode: hit[i] = ((s_araddr & MASK[i]) == BASE[i]). Lowest index wins. No hit means unmapped.
- State IDLE (cnt==0):
  - s_arready=1 when the AR stage is empty.
  - Mapped handshake: tgt<=sel, cnt<=1, go to BUSY.
  - Unmapped handshake: go to DECERR.
- State BUSY:
  - s_arready = AR stage empty or draining, and hit[tgt] for the presented address, and cnt<MAX_OUT.
  - Any other target: s_arready=0 until cnt returns to 0, then state=IDLE.
- State DECERR:
  - s_arready=0.
  - s_rvalid=1, s_rresp=2'b11, s_rdata=0, held until s_rready; then IDLE.
- AR stage (one entry):
  - A mapped s_ar handshake loads m_araddr and asserts m_arvalid[tgt] the next cycle. AR latency is 1 cycle.
  - m_arvalid is held, with m_araddr stable, until m_arready[tgt].
  - On a same-cycle drain and new accept, the stage reloads with no bubble.
  - Only one m_arvalid bit is ever set.
- R path (combinational):
  - s_rvalid=m_rvalid[tgt], s_rdata/s_rresp from port tgt.
  - m_rready[i]=s_rready & (i==tgt) & (state==BUSY).
  - Responses on non-target ports are not accepted.
- cnt, width $clog2(MAX_OUT+1):
  - +1 on mapped s_ar handshake.
  - -1 on s_r handshake in BUSY.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUT. Never wraps below 0; a response with cnt==0 is not acceptable (m_rready=0).
- BUSY to IDLE occurs on the cycle cnt reaches 0. A new AR for another target is accepted from the following cycle.
- Reset mid-transaction drops all outstanding state. Downstream ports must be reset together.

Test Plan:
- NM=4, BASE={0x3000,0x2000,0x1000,0x0000}, MASK=0xF000 each. Read 0x1004, m_arready=1 at once, port 1 returns rdata=0xA5A5A5A5, rresp=0 two cycles later -> m_arvalid=4'b0010 one cycle after the s_ar handshake; s_rdata=0xA5A5A5A5, s_rresp=0; cnt returns to 0.
- Four back-to-back reads to 0x2000..0x200C, MAX_OUT=4, responses withheld -> four AR handshakes on port 2; a fifth AR sees s_arready=0 until the first response; final cnt=0.
- Read to 0x0000 then 0x3000, port 0 response delayed 5 cycles -> the 0x3000 AR stalls (s_arready=0) until the port 0 response is accepted, then m_arvalid=4'b1000.
- Read 0x8000 (unmapped) -> no m_arvalid; s_rvalid=1, s_rresp=2'b11, s_rdata=0; held for 3 cycles with s_rready=0, then completes.
- Spurious m_rvalid[3]=1 while tgt=1 -> m_rready[3]=0 and s_rvalid follows port 1 only.
- aresetn low for 1 cycle with cnt=2 and m_arvalid set -> all outputs clear immediately (async); after release s_arready=1 and cnt=0.
